gzip_job_sequencer: RTL and testbench
=====================================

// Module: gzip_job_sequencer
// PURPOSE
//  Sequences one compression job on the gzip core: pulses the core reset, applies btype, meters
//  exactly cfg_job_words 32-bit words from an upstream stream into the core input FIFO, then waits
//  for core done. Captures ISIZE/CRC32, reports status/error code, raises a sticky irq.
//  Sits between the register block / input stream adapter and the gzip core in the core_clock domain.
// PARAMETERS
//  RST_CYCLES      16        cycles core_rst_n is held low before feeding (>=1)
//  LEN_W           24        width of job length counter (words)
//  TIMEOUT_CYCLES  1048576   drain watchdog limit (used only with GZIP_SEQ_TIMEOUT_EN)
// PORTS
//  core_clock            in   1      single clock for all logic
//  bus_reset             in   1      asynchronous, active-high reset
//  cfg_start             in   1      1-cycle job start pulse
//  cfg_abort             in   1      1-cycle abort pulse
//  cfg_btype             in   2      compression mode, sampled on accepted start
//  cfg_job_words         in   LEN_W  job length in words, sampled on accepted start
//  irq_clear             in   1      clears irq
//  s_tdata/s_tvalid      in   32/1   upstream word stream
//  s_tready              out  1      upstream ready
//  fifo_din/fifo_wr_en   out  32/1   core input FIFO write
//  fifo_full             in   1      core input FIFO full
//  core_rst_n/core_btype out  1/2    core reset (active-low) and mode
//  core_done             in   1      core finished (level)
//  core_btype_err/core_bsize_err in 1/1  core error flags (level)
//  core_isize/core_crc   in   32/32  core result words
//  busy                  out  1      job in progress
//  err_code              out  3      0 none,1 bad btype,2 zero length,3 core btype,4 core bsize,5 abort,6 timeout
//  res_isize/res_crc     out  32/32  captured results
//  irq                   out  1      sticky job-finished interrupt
// BEHAVIOUR
//  Reset: state IDLE; core_rst_n=0, core_btype=0, s_tready=0, fifo_wr_en=0, busy=0, err_code=0,
//   res_*=0, irq=0, counters 0. All outputs registered except s_tready/fifo_wr_en/fifo_din (comb).
//  States: IDLE, CORE_RST, FEED, DRAIN, DONE, ERROR. busy=1 in CORE_RST/FEED/DRAIN.
//  cfg_start accepted only in IDLE/DONE/ERROR; ignored while busy. On accept: clear err_code,
//   latch btype/len. btype==2'b11 -> ERROR code 1; len==0 -> ERROR code 2 (core untouched, btype first).
//   Otherwise -> CORE_RST, core_rst_n=0 for exactly RST_CYCLES cycles, core_btype=latched btype.
//  CORE_RST -> FEED: core_rst_n=1 on the first FEED cycle.
//  FEED: s_tready = ~fifo_full & (words_left!=0); fifo_wr_en = s_tvalid & s_tready; fifo_din = s_tdata,
//   zero latency. words_left decrements per transfer; transfer with words_left==1 -> DRAIN next cycle.
//   Words beyond job length are never accepted (s_tready=0 outside FEED).
//  DRAIN: core_done=1 -> capture res_isize/res_crc same edge, -> DONE. core_rst_n stays 1 in DONE.
//  In FEED/DRAIN: core_btype_err -> ERROR code 3; core_bsize_err -> ERROR code 4 (btype wins if both);
//   core errors take priority over core_done in the same cycle.
//  cfg_abort while busy -> ERROR code 5; abort beats start/done/errors in same cycle; ignored when idle.
//  ERROR: core_rst_n=0 (held until next accepted start). irq set on entry to DONE or ERROR.
//  irq cleared by irq_clear; set and clear in same cycle -> irq=1. bus_reset mid-job -> reset values.
// CONFIGURATION
//  GZIP_SEQ_TIMEOUT_EN defined: counter cleared on DRAIN entry, increments each DRAIN cycle;
//   reaching TIMEOUT_CYCLES without core_done -> ERROR code 6. core_done on the limit cycle wins.
//  Not defined: no counter; DRAIN waits indefinitely; code 6 never produced.
// TESTING
//  RST_CYCLES=16, start btype=01 len=4, stream 4 words -> core_rst_n low 16 cycles, 4 fifo_wr_en, DRAIN.
//  core_done with isize=16 crc=0xCBF43926 -> res captured, DONE, irq=1, busy=0; irq_clear -> irq=0.
//  fifo_full held 5 cycles mid-FEED -> s_tready=0, no writes, word count still exactly 4; s_tvalid 5th word -> not taken.
//  start btype=11 -> ERROR code 1, irq=1, core_rst_n never released; start len=0 -> code 2.
//  cfg_abort in FEED after 2 words -> ERROR code 5, core_rst_n=0 next cycle; core_bsize_err in DRAIN -> code 4.
//  With GZIP_SEQ_TIMEOUT_EN, TIMEOUT_CYCLES=100, no core_done -> ERROR code 6 after 100 DRAIN cycles.

Source files
------------

// File: rtl/gzip_job_sequencer.sv
// gzip_job_sequencer
//   Runs one compression job on the gzip core: pulses the core reset, applies
//   the compression mode, meters exactly cfg_job_words 32-bit words from the
//   upstream stream into the core input FIFO, then waits for core done.
//   Captures ISIZE/CRC32, reports an error code and raises a sticky irq.
//
//   Optional build macro: GZIP_SEQ_TIMEOUT_EN enables the drain watchdog
//   (ERROR code 6 after TIMEOUT_CYCLES DRAIN cycles without core_done).
//
// Ports
//   core_clock, bus_reset           clock, async active-high reset
//   cfg_start/cfg_abort             1-cycle job start / abort pulses
//   cfg_btype/cfg_job_words         job mode and length, sampled on accepted start
//   irq_clear                       clears irq (set wins when simultaneous)
//   s_tdata/s_tvalid/s_tready       upstream word stream
//   fifo_din/fifo_wr_en/fifo_full   core input FIFO write side
//   core_rst_n/core_btype           core reset (active-low) and mode
//   core_done/core_*_err            core status (levels)
//   core_isize/core_crc             core result words
//   busy/err_code/res_isize/res_crc job status and captured results
//   irq                             sticky job-finished interrupt
module gzip_job_sequencer #(
   parameter int RST_CYCLES     = 16,
   parameter int LEN_W          = 24,
   parameter int TIMEOUT_CYCLES = 1048576
) (
   input  logic             core_clock,
   input  logic             bus_reset,
   input  logic             cfg_start,
   input  logic             cfg_abort,
   input  logic [1:0]       cfg_btype,
   input  logic [LEN_W-1:0] cfg_job_words,
   input  logic             irq_clear,
   input  logic [31:0]      s_tdata,
   input  logic             s_tvalid,
   output logic             s_tready,
   output logic [31:0]      fifo_din,
   output logic             fifo_wr_en,
   input  logic             fifo_full,
   output logic             core_rst_n,
   output logic [1:0]       core_btype,
   input  logic             core_done,
   input  logic             core_btype_err,
   input  logic             core_bsize_err,
   input  logic [31:0]      core_isize,
   input  logic [31:0]      core_crc,
   output logic             busy,
   output logic [2:0]       err_code,
   output logic [31:0]      res_isize,
   output logic [31:0]      res_crc,
   output logic             irq
);

   localparam int RC_W = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;

   typedef enum logic [2:0] {IDLE, CORE_RST, FEED, DRAIN, DONE, ERROR} state_t;

   state_t           state, state_nxt;
   logic [RC_W-1:0]  rst_cnt, rst_cnt_nxt;
   logic [LEN_W-1:0] words_left, words_left_nxt;
   logic [2:0]       err_nxt;
   logic [1:0]       btype_nxt;
   logic             rst_n_nxt;
   logic             irq_set;
   logic             capture;
   logic             in_job;
   logic             wd_expired;

   assign in_job     = (state == CORE_RST) || (state == FEED) || (state == DRAIN);
   assign s_tready   = (state == FEED) && !fifo_full && (words_left != '0);
   assign fifo_wr_en = s_tvalid && s_tready;
   assign fifo_din   = s_tdata;

`ifdef GZIP_SEQ_TIMEOUT_EN
   localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);
   logic [WD_W-1:0] wd_cnt;

   // Holds zero outside DRAIN, so it starts from zero on every DRAIN entry;
   // it reads n-1 during the n-th DRAIN cycle.
   always_ff @(posedge core_clock or posedge bus_reset) begin
      if (bus_reset)             wd_cnt <= '0;
      else if (state != DRAIN)   wd_cnt <= '0;
      else                       wd_cnt <= wd_cnt + 1'b1;
   end

   assign wd_expired = (wd_cnt == WD_W'(TIMEOUT_CYCLES - 1));
`else
   logic unused_timeout;
   assign unused_timeout = TIMEOUT_CYCLES[0];
   assign wd_expired     = 1'b0;
`endif

   always_ff @(posedge core_clock or posedge bus_reset) begin
      if (bus_reset) begin
         state      <= IDLE;
         rst_cnt    <= '0;
         words_left <= '0;
         core_rst_n <= 1'b0;
         core_btype <= 2'b00;
         busy       <= 1'b0;
         err_code   <= 3'd0;
         res_isize  <= '0;
         res_crc    <= '0;
         irq        <= 1'b0;
      end else begin
         state      <= state_nxt;
         rst_cnt    <= rst_cnt_nxt;
         words_left <= words_left_nxt;
         core_rst_n <= rst_n_nxt;
         core_btype <= btype_nxt;
         busy       <= (state_nxt == CORE_RST) || (state_nxt == FEED) || (state_nxt == DRAIN);
         err_code   <= err_nxt;
         irq        <= irq_set || (irq && !irq_clear);
         if (capture) begin
            res_isize <= core_isize;
            res_crc   <= core_crc;
         end
      end
   end

   always_comb begin
      state_nxt      = state;
      rst_cnt_nxt    = rst_cnt;
      words_left_nxt = words_left;
      err_nxt        = err_code;
      btype_nxt      = core_btype;
      rst_n_nxt      = core_rst_n;
      irq_set        = 1'b0;
      capture        = 1'b0;

      case (state)
         IDLE, DONE, ERROR: begin
            if (cfg_start) begin
               err_nxt = 3'd0;
               if (cfg_btype == 2'b11) begin
                  state_nxt = ERROR;
                  err_nxt   = 3'd1;
                  rst_n_nxt = 1'b0;
                  irq_set   = 1'b1;
               end else if (cfg_job_words == '0) begin
                  state_nxt = ERROR;
                  err_nxt   = 3'd2;
                  rst_n_nxt = 1'b0;
                  irq_set   = 1'b1;
               end else begin
                  state_nxt      = CORE_RST;
                  rst_cnt_nxt    = RC_W'(RST_CYCLES - 1);
                  words_left_nxt = cfg_job_words;
                  btype_nxt      = cfg_btype;
                  rst_n_nxt      = 1'b0;
               end
            end
         end
         CORE_RST: begin
            if (rst_cnt == '0) begin
               state_nxt = FEED;
               rst_n_nxt = 1'b1;
            end else begin
               rst_cnt_nxt = rst_cnt - 1'b1;
            end
         end
         FEED: begin
            if (fifo_wr_en) begin
               words_left_nxt = words_left - 1'b1;
               if (words_left == LEN_W'(1)) state_nxt = DRAIN;
            end
         end
         DRAIN: begin
            if (core_done) begin
               state_nxt = DONE;
               capture   = 1'b1;
               irq_set   = 1'b1;
            end else if (wd_expired) begin
               state_nxt = ERROR;
               err_nxt   = 3'd6;
               rst_n_nxt = 1'b0;
               irq_set   = 1'b1;
            end
         end
         default: state_nxt = IDLE;
      endcase

      // Core error flags override a same-cycle core_done.
      if (((state == FEED) || (state == DRAIN)) && (core_btype_err || core_bsize_err)) begin
         state_nxt = ERROR;
         err_nxt   = core_btype_err ? 3'd3 : 3'd4;
         rst_n_nxt = 1'b0;
         irq_set   = 1'b1;
         capture   = 1'b0;
      end

      // Abort overrides everything else while a job is running.
      if (in_job && cfg_abort) begin
         state_nxt = ERROR;
         err_nxt   = 3'd5;
         rst_n_nxt = 1'b0;
         irq_set   = 1'b1;
         capture   = 1'b0;
      end
   end

endmodule

// File: tb/tb_gzip_job_sequencer.sv
// Bench for gzip_job_sequencer: directed scenarios followed by randomized jobs,
// checked against an outcome model (expected error code, written word stream,
// captured results, irq) derived from the job parameters.
module tb_gzip_job_sequencer;

   localparam int LEN_W = 24;

   logic             core_clock = 1'b0;
   logic             bus_reset;
   logic             cfg_start, cfg_abort, irq_clear;
   logic [1:0]       cfg_btype;
   logic [LEN_W-1:0] cfg_job_words;
   logic [31:0]      s_tdata;
   logic             s_tvalid, s_tready;
   logic [31:0]      fifo_din;
   logic             fifo_wr_en, fifo_full;
   logic             core_rst_n;
   logic [1:0]       core_btype;
   logic             core_done, core_btype_err, core_bsize_err;
   logic [31:0]      core_isize, core_crc;
   logic             busy;
   logic [2:0]       err_code;
   logic [31:0]      res_isize, res_crc;
   logic             irq;

   gzip_job_sequencer #(.RST_CYCLES(16), .LEN_W(LEN_W), .TIMEOUT_CYCLES(100)) dut (
      .core_clock(core_clock), .bus_reset(bus_reset),
      .cfg_start(cfg_start), .cfg_abort(cfg_abort), .cfg_btype(cfg_btype),
      .cfg_job_words(cfg_job_words), .irq_clear(irq_clear),
      .s_tdata(s_tdata), .s_tvalid(s_tvalid), .s_tready(s_tready),
      .fifo_din(fifo_din), .fifo_wr_en(fifo_wr_en), .fifo_full(fifo_full),
      .core_rst_n(core_rst_n), .core_btype(core_btype), .core_done(core_done),
      .core_btype_err(core_btype_err), .core_bsize_err(core_bsize_err),
      .core_isize(core_isize), .core_crc(core_crc), .busy(busy),
      .err_code(err_code), .res_isize(res_isize), .res_crc(res_crc), .irq(irq)
   );

   always #5 core_clock = ~core_clock;

   int          n_cmp = 0;
   int          n_err = 0;
   int          wr_cnt;
   logic [31:0] words[16];
   logic [31:0] model_isize, model_crc;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge core_clock);
      #1;
   endtask

   task automatic new_words();
      for (int i = 0; i < 16; i++) words[i] = $urandom;
      wr_cnt = 0;
   endtask

   task automatic start_job(input logic [1:0] bt, input int len);
      cfg_btype = bt; cfg_job_words = LEN_W'(len); cfg_start = 1'b1;
      step();
      cfg_start = 1'b0;
   endtask

   // One stream cycle; any FIFO write is checked against the next job word.
   task automatic drive(input logic v, input logic f);
      s_tvalid = v; fifo_full = f; s_tdata = words[wr_cnt % 16];
      #1;
      if (f) chk("full_blocks_tready", {31'd0, s_tready}, 32'd0);
      if (fifo_wr_en === 1'b1) begin
         chk("wr_data", fifo_din, words[wr_cnt % 16]);
         chk("wr_handshake", {30'd0, s_tvalid, fifo_full}, 32'd2);
         wr_cnt++;
      end
      step();
      s_tvalid = 1'b0; fifo_full = 1'b0;
   endtask

   task automatic wait_core_rst(input logic [1:0] bt);
      int cnt = 0;
      s_tvalid = 1'b1; fifo_full = 1'b0; s_tdata = words[0];
      while (core_rst_n === 1'b0 && cnt < 64) begin
         #1;
         chk("rst_no_write", {31'd0, fifo_wr_en}, 32'd0);
         cnt++;
         step();
      end
      s_tvalid = 1'b0;
      chk("rst_cycles", cnt, 16);
      chk("core_btype", {30'd0, core_btype}, {30'd0, bt});
   endtask

   task automatic feed_to(input int target);
      int cyc = 0;
      while (wr_cnt < target && cyc < 300) begin
         drive($urandom_range(0, 3) != 0, $urandom_range(0, 3) == 0);
         cyc++;
      end
      chk("feed_count", wr_cnt, target);
   endtask

   task automatic no_overrun(input int len);
      repeat (3) drive(1'b1, 1'b0);
      chk("no_extra_word", wr_cnt, len);
      chk("drain_busy", {31'd0, busy}, 32'd1);
   endtask

   task automatic drain_end(input logic d, input logic be, input logic se,
                            input logic [31:0] isz, input logic [31:0] crc);
      core_done = d; core_btype_err = be; core_bsize_err = se;
      core_isize = isz; core_crc = crc;
      step();
      core_done = 1'b0; core_btype_err = 1'b0; core_bsize_err = 1'b0;
   endtask

   task automatic check_end(input int code);
      chk("err_code", {29'd0, err_code}, code);
      chk("end_busy", {31'd0, busy}, 32'd0);
      chk("end_irq", {31'd0, irq}, 32'd1);
      chk("end_core_rst_n", {31'd0, core_rst_n}, (code == 0) ? 32'd1 : 32'd0);
      chk("res_isize", res_isize, model_isize);
      chk("res_crc", res_crc, model_crc);
   endtask

   function automatic int exp_code(input int bt, input int len, input int scen);
      if (bt == 3) return 1;
      if (len == 0) return 2;
      case (scen)
         0:       return 0;
         1:       return 5;
         2:       return 3;
         3:       return 4;
         4:       return 3;
         default: return 4;
      endcase
   endfunction

   initial begin
      logic [31:0] isz, crc;
      int          bt, len, scen, code, cnt;

      bus_reset = 1'b1; cfg_start = 1'b0; cfg_abort = 1'b0; irq_clear = 1'b0;
      cfg_btype = 2'b00; cfg_job_words = '0; s_tdata = '0; s_tvalid = 1'b0;
      fifo_full = 1'b0; core_done = 1'b0; core_btype_err = 1'b0; core_bsize_err = 1'b0;
      core_isize = '0; core_crc = '0;
      model_isize = '0; model_crc = '0;
      new_words();
      step(); step();
      chk("rst_busy", {31'd0, busy}, 32'd0);
      chk("rst_err", {29'd0, err_code}, 32'd0);
      chk("rst_irq", {31'd0, irq}, 32'd0);
      chk("rst_core_rst_n", {31'd0, core_rst_n}, 32'd0);
      chk("rst_core_btype", {30'd0, core_btype}, 32'd0);
      chk("rst_res", res_isize | res_crc, 32'd0);
      bus_reset = 1'b0;
      step();

      // Abort while idle has no effect.
      cfg_abort = 1'b1; step(); cfg_abort = 1'b0;
      chk("idle_abort_err", {29'd0, err_code}, 32'd0);
      chk("idle_abort_irq", {31'd0, irq}, 32'd0);

      // Reference job: 4 words with a 5-cycle full stall after two words.
      new_words();
      start_job(2'b01, 4);
      chk("start_busy", {31'd0, busy}, 32'd1);
      wait_core_rst(2'b01);
      drive(1'b1, 1'b0); drive(1'b1, 1'b0);
      repeat (5) drive(1'b1, 1'b1);
      chk("stall_count", wr_cnt, 2);
      feed_to(4);
      no_overrun(4);
      chk("drain_core_rst_n", {31'd0, core_rst_n}, 32'd1);
      drain_end(1'b1, 1'b0, 1'b0, 32'd16, 32'hCBF43926);
      model_isize = 32'd16; model_crc = 32'hCBF43926;
      check_end(0);
      irq_clear = 1'b1; step(); irq_clear = 1'b0;
      chk("irq_clear", {31'd0, irq}, 32'd0);

      // Start pulse while busy is ignored.
      new_words();
      start_job(2'b10, 3);
      wait_core_rst(2'b10);
      feed_to(1);
      cfg_start = 1'b1; cfg_btype = 2'b11;
      drive(1'b0, 1'b0);
      cfg_start = 1'b0;
      chk("busy_start_ignored", {31'd0, busy}, 32'd1);
      chk("busy_start_err", {29'd0, err_code}, 32'd0);
      feed_to(3);
      isz = $urandom; crc = $urandom;
      drain_end(1'b1, 1'b0, 1'b0, isz, crc);
      model_isize = isz; model_crc = crc;
      check_end(0);

      // Bad btype with irq_clear in the same cycle: set wins.
      irq_clear = 1'b1; step();
      start_job(2'b11, 5);
      irq_clear = 1'b0;
      check_end(1);
      repeat (3) step();
      chk("bad_btype_rst_held", {31'd0, core_rst_n}, 32'd0);

      // Zero length.
      start_job(2'b01, 0);
      check_end(2);

      // Abort after two words.
      new_words();
      start_job(2'b10, 6);
      wait_core_rst(2'b10);
      feed_to(2);
      cfg_abort = 1'b1; step(); cfg_abort = 1'b0;
      check_end(5);

      // Block-size error in DRAIN.
      new_words();
      start_job(2'b00, 3);
      wait_core_rst(2'b00);
      feed_to(3);
      drain_end(1'b0, 1'b0, 1'b1, 32'h1234, 32'h5678);
      check_end(4);

      // Reset in the middle of a job.
      new_words();
      start_job(2'b01, 5);
      wait_core_rst(2'b01);
      feed_to(2);
      bus_reset = 1'b1;
      #1;
      chk("midrst_busy", {31'd0, busy}, 32'd0);
      chk("midrst_irq", {31'd0, irq}, 32'd0);
      chk("midrst_err", {29'd0, err_code}, 32'd0);
      chk("midrst_core_rst_n", {31'd0, core_rst_n}, 32'd0);
      chk("midrst_res", res_isize | res_crc, 32'd0);
      model_isize = '0; model_crc = '0;
      step();
      bus_reset = 1'b0;
      step();

      // Randomized jobs.
      for (int j = 0; j < 14; j++) begin
         bt   = $urandom_range(0, 3);
         len  = ($urandom_range(0, 5) == 0) ? 0 : $urandom_range(1, 8);
         scen = $urandom_range(0, 5);
         code = exp_code(bt, len, scen);
         isz  = $urandom; crc = $urandom;
         new_words();
         start_job(bt[1:0], len);
         if (code > 2) begin
            wait_core_rst(bt[1:0]);
            if (scen == 0) begin
               chk("rand_core_rst_n", {31'd0, core_rst_n}, 32'd1);
            end
            if (scen == 1) begin
               feed_to((len < 2) ? len : 2);
               cfg_abort = 1'b1;
               drain_end(1'b1, 1'b1, 1'b0, isz, crc);
               cfg_abort = 1'b0;
            end else if (scen == 2) begin
               feed_to(len / 2);
               drain_end(1'b0, 1'b1, 1'b0, isz, crc);
            end else begin
               feed_to(len);
               no_overrun(len);
               repeat ($urandom_range(0, 3)) drive(1'b0, 1'b0);
               case (scen)
                  3:       drain_end(1'b0, 1'b0, 1'b1, isz, crc);
                  4:       drain_end(1'b1, 1'b1, 1'b1, isz, crc);
                  default: drain_end(1'b1, 1'b0, 1'b1, isz, crc);
               endcase
            end
         end else if (code == 0) begin
            wait_core_rst(bt[1:0]);
            feed_to(len);
            no_overrun(len);
            drain_end(1'b1, 1'b0, 1'b0, isz, crc);
         end
         if (code == 0) begin
            model_isize = isz; model_crc = crc;
         end
         check_end(code);
         if ($urandom_range(0, 1) == 1) begin
            irq_clear = 1'b1; step(); irq_clear = 1'b0;
            chk("rand_irq_clear", {31'd0, irq}, 32'd0);
         end
      end

`ifdef GZIP_SEQ_TIMEOUT_EN
      new_words();
      start_job(2'b01, 2);
      wait_core_rst(2'b01);
      feed_to(2);
      cnt = 0;
      while (busy === 1'b1 && cnt < 300) begin
         cnt++;
         step();
      end
      chk("timeout_cycles", cnt, 100);
      check_end(6);
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
